// File: rtl/mem_arb_pkg.sv
// Shared types for the backing-memory arbiter.
// States, requester ids and round-robin classes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT,
    ARB_DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    SRC_IC,
    SRC_DL,
    SRC_DE
  } arb_src_t;

  typedef enum logic {
    CLS_INST,
    CLS_DATA
  } arb_class_t;

  function automatic arb_class_t src_class(
    arb_src_t s
  );
    return (s == SRC_IC) ? CLS_INST : CLS_DATA;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory signals of the arbiter.
// slave = arbiter side, master = environment side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_done;
  logic [DATA_W-1:0] ic_rdata;

  logic              dl_req;
  logic [ADDR_W-1:0] dl_addr;
  logic              dl_done;
  logic [DATA_W-1:0] dl_rdata;

  logic              de_req;
  logic [ADDR_W-1:0] de_addr;
  logic [DATA_W-1:0] de_wdata;
  logic              de_done;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  ic_req, ic_addr,
    input  dl_req, dl_addr,
    input  de_req, de_addr, de_wdata,
    input  mem_rdata, mem_ready,
    output ic_done, ic_rdata,
    output dl_done, dl_rdata,
    output de_done,
    output mem_req, mem_we,
    output mem_addr, mem_wdata
  );

  modport master (
    output ic_req, ic_addr,
    output dl_req, dl_addr,
    output de_req, de_addr, de_wdata,
    output mem_rdata, mem_ready,
    input  ic_done, ic_rdata,
    input  dl_done, dl_rdata,
    input  de_done,
    input  mem_req, mem_we,
    input  mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Grant picker: evict beats load in the data class,
// round-robin between instruction and data classes.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_ic_req,
  input  logic       i_dl_req,
  input  logic       i_de_req,
  input  arb_class_t i_rr_last,
  output logic       o_gnt_valid,
  output arb_src_t   o_gnt_src
);

  logic     w_inst;
  logic     w_data;
  arb_src_t w_data_src;

  assign w_inst = i_ic_req;
  assign w_data = i_dl_req | i_de_req;
  // write-back must reach memory before a refill load
  assign w_data_src = i_de_req ? SRC_DE : SRC_DL;

  always_comb begin
    o_gnt_valid = w_inst | w_data;
    o_gnt_src   = SRC_IC;
    unique case (1'b1)
      (w_inst && w_data):
        o_gnt_src = (i_rr_last == CLS_INST)
                  ? w_data_src : SRC_IC;
      (w_data && !w_inst):
        o_gnt_src = w_data_src;
      default:
        o_gnt_src = SRC_IC;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Backing-memory arbiter: one word transaction at a
// time for icache refill, MSHR load and MSHR evict.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  output logic         busy,
  output logic         timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t        r_state;
  arb_state_t        w_next;
  arb_src_t          r_src;
  arb_class_t        r_rr;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic [DATA_W-1:0] r_ic_rdata;
  logic [DATA_W-1:0] r_dl_rdata;

  logic              w_gnt_valid;
  arb_src_t          w_gnt_src;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic              w_grant;
  logic              w_expire;
  logic              w_finish;
  logic [DATA_W-1:0] w_rdata;

  mem_arb_pick u_pick (
    .i_ic_req    (bus.ic_req),
    .i_dl_req    (bus.dl_req),
    .i_de_req    (bus.de_req),
    .i_rr_last   (r_rr),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_src   (w_gnt_src)
  );

  always_comb begin
    w_gnt_addr = bus.ic_addr;
    unique case (w_gnt_src)
      SRC_IC:  w_gnt_addr = bus.ic_addr;
      SRC_DL:  w_gnt_addr = bus.dl_addr;
      SRC_DE:  w_gnt_addr = bus.de_addr;
      default: w_gnt_addr = bus.ic_addr;
    endcase
  end

  assign w_grant  = (r_state == ARB_IDLE)
                  && w_gnt_valid;
  // ready wins over the watchdog on the same cycle
  assign w_expire = (r_state == ARB_WAIT)
                  && !bus.mem_ready
                  && (r_cnt == CNT_LAST);
  assign w_finish =
    ((r_state == ARB_REQ) && bus.mem_ready)
    || ((r_state == ARB_WAIT)
        && (bus.mem_ready || w_expire));
  assign w_rdata  = bus.mem_ready
                  ? bus.mem_rdata : '0;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ARB_IDLE: if (w_gnt_valid) w_next = ARB_REQ;
      ARB_REQ:  w_next = w_finish ? ARB_DONE
                                  : ARB_WAIT;
      ARB_WAIT: if (w_finish) w_next = ARB_DONE;
      ARB_DONE: w_next = ARB_IDLE;
      default:  w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ARB_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_src      <= SRC_IC;
      r_rr       <= CLS_DATA;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_ic_rdata <= '0;
      r_dl_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_src  <= w_gnt_src;
        r_rr   <= src_class(w_gnt_src);
        r_we   <= (w_gnt_src == SRC_DE);
        r_addr <= w_gnt_addr;
        if (w_gnt_src == SRC_DE)
          r_wdata <= bus.de_wdata;
      end
      if (r_state == ARB_REQ)
        r_cnt <= '0;
      else if ((r_state == ARB_WAIT) && !w_finish)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_expire)
        r_err <= 1'b1;
      if (w_finish && (r_src == SRC_IC))
        r_ic_rdata <= w_rdata;
      if (w_finish && (r_src == SRC_DL))
        r_dl_rdata <= w_rdata;
    end
  end

  assign bus.mem_req   = (r_state == ARB_REQ);
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

  assign bus.ic_done  = (r_state == ARB_DONE)
                      && (r_src == SRC_IC);
  assign bus.dl_done  = (r_state == ARB_DONE)
                      && (r_src == SRC_DL);
  assign bus.de_done  = (r_state == ARB_DONE)
                      && (r_src == SRC_DE);
  assign bus.ic_rdata = r_ic_rdata;
  assign bus.dl_rdata = r_dl_rdata;

  assign busy        = (r_state != ARB_IDLE);
  assign timeout_err = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory
// commands and done pulses queued at stimulus time.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic timeout_err;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    int          src;
    logic [31:0] rdata;
  } done_t;

  cmd_t        exp_cmd[$];
  done_t       exp_done[$];
  logic [31:0] mem [logic [31:0]];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int lat = 0;
  int mem_cnt = 0;
  int ic_left = 0;
  int dl_left = 0;
  int de_left = 0;
  logic        p_we;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;

  function automatic logic [31:0] mem_val(
    logic [31:0] a
  );
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic push_cmd(logic we, logic [31:0] a,
                          logic [31:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = d;
    exp_cmd.push_back(c);
  endtask

  task automatic push_done(int s, logic [31:0] d);
    done_t e;
    e.src = s; e.rdata = d;
    exp_done.push_back(e);
  endtask

  task automatic respond();
    bus.mem_ready = 1'b1;
    if (p_we) mem[p_addr] = p_wdata;
    else      bus.mem_rdata = mem_val(p_addr);
  endtask

  // one cycle: memory model, scoreboard, requesters
  task automatic tick();
    cmd_t        c;
    done_t       e;
    int          nd;
    int          src;
    logic [31:0] rd;
    @(negedge clk);
    cyc++;
    bus.mem_ready = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) respond();
    end else if (bus.mem_req && rst) begin
      p_we    = bus.mem_we;
      p_addr  = bus.mem_addr;
      p_wdata = bus.mem_wdata;
      if (lat == 0) respond();
      else if (lat > 0) mem_cnt = lat;
    end
    if (bus.mem_req) begin
      n_vec++;
      if (exp_cmd.size() == 0) begin
        n_err++;
        $display("FAIL cmd_unexpected: got we=%0b addr=%h, required none",
                 bus.mem_we, bus.mem_addr);
      end else begin
        c = exp_cmd.pop_front();
        if (bus.mem_we !== c.we
            || bus.mem_addr !== c.addr
            || (c.we && bus.mem_wdata !== c.wdata)) begin
          n_err++;
          $display("FAIL cmd: got we=%0b addr=%h wd=%h, required we=%0b addr=%h wd=%h",
                   bus.mem_we, bus.mem_addr, bus.mem_wdata,
                   c.we, c.addr, c.wdata);
        end
      end
    end
    nd = int'(bus.ic_done) + int'(bus.dl_done)
       + int'(bus.de_done);
    if (nd > 0) begin
      src = bus.ic_done ? 0 : (bus.dl_done ? 1 : 2);
      rd  = (src == 0) ? bus.ic_rdata : bus.dl_rdata;
      n_vec++;
      if (exp_done.size() == 0) begin
        n_err++;
        $display("FAIL done_unexpected: got src=%0d, required none",
                 src);
      end else begin
        e = exp_done.pop_front();
        if (nd != 1 || src != e.src
            || (src != 2 && rd !== e.rdata)) begin
          n_err++;
          $display("FAIL done: got src=%0d n=%0d rdata=%h, required src=%0d rdata=%h",
                   src, nd, rd, e.src, e.rdata);
        end
      end
    end
    if (bus.ic_done && ic_left > 0) begin
      ic_left--;
      if (ic_left == 0) bus.ic_req = 1'b0;
    end
    if (bus.dl_done && dl_left > 0) begin
      dl_left--;
      if (dl_left == 0) bus.dl_req = 1'b0;
    end
    if (bus.de_done && de_left > 0) begin
      de_left--;
      if (de_left == 0) bus.de_req = 1'b0;
    end
  endtask

  task automatic wait_idle(int max, string name);
    int  n = 0;
    bit  ok = 1'b0;
    while (!ok && n < max) begin
      tick();
      n++;
      ok = (ic_left == 0 && dl_left == 0
            && de_left == 0 && !busy);
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_idle: got busy after %0d cycles, required idle",
               name, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mem_cnt = 0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus.ic_req = 0; bus.ic_addr = '0;
    bus.dl_req = 0; bus.dl_addr = '0;
    bus.de_req = 0; bus.de_addr = '0;
    bus.de_wdata = '0;
    bus.mem_ready = 0; bus.mem_rdata = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({busy, timeout_err, bus.mem_req,
         bus.mem_we} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctl: got %b, required 0000",
               {busy, timeout_err, bus.mem_req,
                bus.mem_we});
    end
    n_vec++;
    if ({bus.ic_done, bus.dl_done,
         bus.de_done} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_done: got %b, required 000",
               {bus.ic_done, bus.dl_done, bus.de_done});
    end
    n_vec++;
    if ({bus.mem_addr, bus.mem_wdata, bus.ic_rdata,
         bus.dl_rdata} !== 128'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h, required 0",
               {bus.mem_addr, bus.mem_wdata,
                bus.ic_rdata, bus.dl_rdata});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    mem[32'h100] = 32'hDEAD_BEEF;
    lat = 0;
    push_cmd(1'b0, 32'h100, '0);
    push_done(0, 32'hDEAD_BEEF);
    bus.ic_addr = 32'h100;
    bus.ic_req  = 1'b1;
    ic_left = 1;
    tick();
    n_vec++;
    if (bus.mem_req !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_req: got req=%0b busy=%0b, required 1 1",
               bus.mem_req, busy);
    end
    tick();
    n_vec++;
    if (bus.ic_done !== 1'b1 || bus.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL single_lat: got done=%0b req=%0b, required 1 0",
               bus.ic_done, bus.mem_req);
    end
    tick();
    n_vec++;
    if (busy !== 1'b0
        || bus.ic_rdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL single_hold: got busy=%0b rdata=%h, required 0 deadbeef",
               busy, bus.ic_rdata);
    end
  endtask

  task automatic test_evict_priority();
    lat = 0;
    push_cmd(1'b1, 32'h40, 32'h11);
    push_cmd(1'b0, 32'h40, '0);
    push_done(2, '0);
    push_done(1, 32'h11);
    bus.de_addr = 32'h40; bus.de_wdata = 32'h11;
    bus.dl_addr = 32'h40;
    bus.de_req = 1'b1; bus.dl_req = 1'b1;
    de_left = 1; dl_left = 1;
    wait_idle(40, "evict");
    n_vec++;
    if (bus.dl_rdata !== 32'h11) begin
      n_err++;
      $display("FAIL evict_order: got dl_rdata=%h, required 00000011",
               bus.dl_rdata);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    lat = 0;
    for (int i = 0; i < 2; i++) begin
      push_cmd(1'b0, 32'h200, '0);
      push_done(0, mem_val(32'h200));
      push_cmd(1'b0, 32'h300, '0);
      push_done(1, mem_val(32'h300));
    end
    bus.ic_addr = 32'h200; bus.dl_addr = 32'h300;
    bus.ic_req = 1'b1; bus.dl_req = 1'b1;
    ic_left = 2; dl_left = 2;
    wait_idle(80, "rr");
  endtask

  task automatic test_wait_states();
    int nreq = 0;
    int req_c = -1;
    int rdy_c = -1;
    int done_c = -1;
    int bad_busy = 0;
    int n = 0;
    lat = 5;
    push_cmd(1'b0, 32'h600, '0);
    push_done(1, mem_val(32'h600));
    bus.dl_addr = 32'h600;
    bus.dl_req = 1'b1;
    dl_left = 1;
    while (done_c < 0 && n < 30) begin
      tick();
      n++;
      if (bus.mem_req) begin
        nreq++;
        req_c = cyc;
      end
      if (req_c >= 0 && !busy) bad_busy++;
      if (bus.mem_ready) rdy_c = cyc;
      if (bus.dl_done) done_c = cyc;
    end
    n_vec++;
    if (nreq != 1 || bad_busy != 0) begin
      n_err++;
      $display("FAIL wait_req: got nreq=%0d busy_drops=%0d, required 1 0",
               nreq, bad_busy);
    end
    n_vec++;
    if (done_c != rdy_c + 1 || done_c != req_c + 6) begin
      n_err++;
      $display("FAIL wait_lat: got done@%0d ready@%0d req@%0d, required ready+1 req+6",
               done_c, rdy_c, req_c);
    end
    wait_idle(10, "wait");
  endtask

  task automatic test_timeout();
    int n = 0;
    lat = -1;
    push_cmd(1'b0, 32'h80, '0);
    push_done(1, '0);
    bus.dl_addr = 32'h80;
    bus.dl_req = 1'b1;
    dl_left = 1;
    tick();
    while (!bus.mem_req && n < 5) begin
      tick();
      n++;
    end
    repeat (TO) tick();
    n_vec++;
    if (timeout_err !== 1'b0 || bus.dl_done !== 1'b0) begin
      n_err++;
      $display("FAIL to_early: got err=%0b done=%0b, required 0 0",
               timeout_err, bus.dl_done);
    end
    tick();
    n_vec++;
    if (timeout_err !== 1'b1 || bus.dl_done !== 1'b1) begin
      n_err++;
      $display("FAIL to_abort: got err=%0b done=%0b, required 1 1",
               timeout_err, bus.dl_done);
    end
    wait_idle(10, "to");
    lat = 0;
    push_cmd(1'b0, 32'h700, '0);
    push_done(0, mem_val(32'h700));
    bus.ic_addr = 32'h700;
    bus.ic_req = 1'b1;
    ic_left = 1;
    wait_idle(20, "to_next");
    n_vec++;
    if (timeout_err !== 1'b1) begin
      n_err++;
      $display("FAIL to_sticky: got err=%0b, required 1",
               timeout_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n = 0;
    lat = -1;
    push_cmd(1'b0, 32'h500, '0);
    bus.ic_addr = 32'h500;
    bus.ic_req = 1'b1;
    ic_left = 1;
    tick();
    while (!bus.mem_req && n < 5) begin
      tick();
      n++;
    end
    repeat (3) tick();
    rst = 1'b0;
    mem_cnt = 0;
    #1;
    n_vec++;
    if ({busy, bus.mem_req, timeout_err,
         bus.ic_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_wait: got %b, required 0000",
               {busy, bus.mem_req, timeout_err,
                bus.ic_done});
    end
    tick();
    lat = 0;
    push_cmd(1'b0, 32'h500, '0);
    push_done(0, mem_val(32'h500));
    rst = 1'b1;
    wait_idle(20, "rst_regrant");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_evict_priority();
    test_round_robin();
    test_wait_states();
    test_timeout();
    test_reset_mid_wait();
    n_vec++;
    if (exp_cmd.size() != 0 || exp_done.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got cmd=%0d done=%0d left, required 0 0",
               exp_cmd.size(), exp_done.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
